// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: widths, ALU opcodes,
// forwarding selects and the ID/EX control bundle.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SHL = 4'b0110;
    localparam logic [3:0] ALU_SHR = 4'b0111;

    typedef enum logic [1:0] {
        FWD_ZERO = 2'b00,
        FWD_REG  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_MEM  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [3:0]        alu_control;
        logic              use_imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_ctrl_t;

endpackage

// File: rtl/fwd_hazard_unit.sv
// Combinational forwarding-select and load-use stall logic for the ID/EX stage.
module fwd_hazard_unit
    import cpu_pkg::*;
(
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output fwd_sel_e          fwd_a_sel,
    output fwd_sel_e          fwd_b_sel,
    output logic              stall_id
);

    logic mem_hits_rs1;
    logic mem_hits_rs2;
    logic wb_hits_rs1;
    logic wb_hits_rs2;
    logic load_in_ex;

    assign mem_hits_rs1 = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1);
    assign mem_hits_rs2 = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2);
    assign wb_hits_rs1  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs1);
    assign wb_hits_rs2  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs2);

    // The MEM stage holds the younger producer, so it outranks WB.
    always_comb begin
        fwd_a_sel = FWD_REG;
        if (ex_rs1 == '0) begin
            fwd_a_sel = FWD_ZERO;
        end else if (mem_hits_rs1) begin
            fwd_a_sel = FWD_MEM;
        end else if (wb_hits_rs1) begin
            fwd_a_sel = FWD_WB;
        end
    end

    always_comb begin
        fwd_b_sel = FWD_REG;
        if (ex_rs2 == '0) begin
            fwd_b_sel = FWD_ZERO;
        end else if (mem_hits_rs2) begin
            fwd_b_sel = FWD_MEM;
        end else if (wb_hits_rs2) begin
            fwd_b_sel = FWD_WB;
        end
    end

    assign load_in_ex = ex_valid && ex_mem_read && (ex_rd != '0);

    assign stall_id = load_in_ex && id_valid &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion;
// drives the ALU operands and opcode combinationally from registered state.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [3:0]        id_alu_control,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [3:0]        ex_alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    id_ex_ctrl_t       ctrl_q;
    id_ex_ctrl_t       ctrl_d;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic [DATA_W-1:0] imm_q;
    fwd_sel_e          fwd_a_sel;
    fwd_sel_e          fwd_b_sel;
    logic [DATA_W-1:0] fwd_rs1;
    logic [DATA_W-1:0] fwd_rs2;

    fwd_hazard_unit u_fwd_hazard (
        .ex_valid      (ctrl_q.valid),
        .ex_mem_read   (ctrl_q.mem_read),
        .ex_rd         (ctrl_q.rd),
        .ex_rs1        (rs1_q),
        .ex_rs2        (rs2_q),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .stall_id      (stall_id)
    );

    // Control bits of an empty ID slot must never reach EX.
    always_comb begin
        ctrl_d             = '0;
        ctrl_d.valid       = id_valid;
        ctrl_d.rd          = id_rd;
        ctrl_d.alu_control = id_alu_control;
        ctrl_d.use_imm     = id_use_imm;
        ctrl_d.reg_write   = id_reg_write & id_valid;
        ctrl_d.mem_read    = id_mem_read  & id_valid;
        ctrl_d.mem_write   = id_mem_write & id_valid;
    end

    // A flush or a load-use stall both load an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else if (flush || stall_id) begin
            ctrl_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
        end
    end

    always_comb begin
        fwd_rs1 = '0;
        case (fwd_a_sel)
            FWD_MEM: fwd_rs1 = mem_result;
            FWD_WB:  fwd_rs1 = wb_result;
            FWD_REG: fwd_rs1 = rs1_data_q;
            default: fwd_rs1 = '0;
        endcase
    end

    always_comb begin
        fwd_rs2 = '0;
        case (fwd_b_sel)
            FWD_MEM: fwd_rs2 = mem_result;
            FWD_WB:  fwd_rs2 = wb_result;
            FWD_REG: fwd_rs2 = rs2_data_q;
            default: fwd_rs2 = '0;
        endcase
    end

    assign ex_a           = fwd_rs1;
    assign ex_b           = ctrl_q.use_imm ? imm_q : fwd_rs2;
    assign ex_store_data  = fwd_rs2;
    assign ex_valid       = ctrl_q.valid;
    assign ex_alu_control = ctrl_q.alu_control;
    assign ex_rd          = ctrl_q.rd;
    assign ex_reg_write   = ctrl_q.reg_write;
    assign ex_mem_read    = ctrl_q.mem_read;
    assign ex_mem_write   = ctrl_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, forwarding,
// load-use stall, R0 guard, flush priority and immediate operand selection.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [DATA_W-1:0] id_rs1_data;
    logic [DATA_W-1:0] id_rs2_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_use_imm;
    logic [3:0]        id_alu_control;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              flush;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [DATA_W-1:0] mem_result;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic [DATA_W-1:0] wb_result;
    logic              stall_id;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [3:0]        ex_alu_control;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;

    int totalChecks = 0;
    int badChecks   = 0;

    id_ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_use_imm     (id_use_imm),
        .id_alu_control (id_alu_control),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .flush          (flush),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_result     (mem_result),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .wb_result      (wb_result),
        .stall_id       (stall_id),
        .ex_valid       (ex_valid),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_alu_control (ex_alu_control),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] rs1,
                                 input logic [2:0] rs2, input logic [2:0] rd,
                                 input logic rs1_used, input logic rs2_used,
                                 input logic [15:0] d1, input logic [15:0] d2,
                                 input logic [15:0] imm, input logic use_imm,
                                 input logic [3:0] alu, input logic rw,
                                 input logic mr, input logic mw);
        id_valid       = valid;
        id_rs1         = rs1;
        id_rs2         = rs2;
        id_rd          = rd;
        id_rs1_used    = rs1_used;
        id_rs2_used    = rs2_used;
        id_rs1_data    = d1;
        id_rs2_data    = d2;
        id_imm         = imm;
        id_use_imm     = use_imm;
        id_alu_control = alu;
        id_reg_write   = rw;
        id_mem_read    = mr;
        id_mem_write   = mw;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, ALU_ADD, 0, 0, 0);
        flush         = 0;
        mem_rd        = 0;
        mem_reg_write = 0;
        mem_result    = 16'h0;
        wb_rd         = 0;
        wb_reg_write  = 0;
        wb_result     = 16'h0;
        rst_n         = 0;
        #12;
        checkOutput("rst_valid", 32'(ex_valid), 32'h0);
        checkOutput("rst_a", 32'(ex_a), 32'h0);
        checkOutput("rst_stall", 32'(stall_id), 32'h0);
        rst_n = 1;

        // ADD R1 <- R2 + R3
        applyStimulus(1, 2, 3, 1, 1, 1, 16'h0005, 16'h0003, 16'h0, 0, ALU_ADD, 1, 0, 0);
        stepClock();
        checkOutput("add_a", 32'(ex_a), 32'h0005);
        checkOutput("add_b", 32'(ex_b), 32'h0003);
        checkOutput("add_alu", 32'(ex_alu_control), 32'h0);
        checkOutput("add_rd", 32'(ex_rd), 32'h1);
        checkOutput("add_rw", 32'(ex_reg_write), 32'h1);
        checkOutput("add_valid", 32'(ex_valid), 32'h1);

        // Store: SW R3 -> [R2+4]
        applyStimulus(1, 2, 3, 0, 1, 1, 16'h0005, 16'h0003, 16'h0004, 1, ALU_ADD, 0, 0, 1);
        stepClock();
        checkOutput("sw_mw", 32'(ex_mem_write), 32'h1);
        checkOutput("sw_b", 32'(ex_b), 32'h0004);
        checkOutput("sw_store", 32'(ex_store_data), 32'h0003);

        // Invalid slot: control bits masked
        applyStimulus(0, 2, 3, 1, 1, 1, 16'h0005, 16'h0003, 16'h0, 0, ALU_ADD, 1, 1, 1);
        stepClock();
        checkOutput("inv_valid", 32'(ex_valid), 32'h0);
        checkOutput("inv_rw", 32'(ex_reg_write), 32'h0);
        checkOutput("inv_mr", 32'(ex_mem_read), 32'h0);
        checkOutput("inv_mw", 32'(ex_mem_write), 32'h0);

        // Forwarding onto rs1=R4: MEM beats WB, WB beats register data
        applyStimulus(1, 4, 0, 2, 1, 0, 16'h0004, 16'h0, 16'h0, 0, ALU_SUB, 1, 0, 0);
        mem_rd = 4; mem_reg_write = 1; mem_result = 16'h1234;
        wb_rd  = 4; wb_reg_write  = 1; wb_result  = 16'hBEEF;
        stepClock();
        checkOutput("fwd_mem", 32'(ex_a), 32'h1234);
        checkOutput("fwd_alu", 32'(ex_alu_control), 32'(ALU_SUB));
        mem_reg_write = 0;
        #1;
        checkOutput("fwd_wb", 32'(ex_a), 32'hBEEF);
        wb_reg_write = 0;
        #1;
        checkOutput("fwd_reg", 32'(ex_a), 32'h0004);

        // Load-use: LW R5 then ADD R6 <- R1 + R5
        applyStimulus(1, 1, 0, 5, 1, 0, 16'h0100, 16'h0, 16'h0010, 1, ALU_ADD, 1, 1, 0);
        stepClock();
        checkOutput("lw_mr", 32'(ex_mem_read), 32'h1);
        applyStimulus(1, 1, 5, 6, 1, 1, 16'h0007, 16'h0009, 16'h0, 0, ALU_ADD, 1, 0, 0);
        #1;
        checkOutput("lu_stall", 32'(stall_id), 32'h1);
        stepClock();
        checkOutput("lu_bub_valid", 32'(ex_valid), 32'h0);
        checkOutput("lu_bub_rw", 32'(ex_reg_write), 32'h0);
        checkOutput("lu_stall_off", 32'(stall_id), 32'h0);
        wb_rd = 5; wb_reg_write = 1; wb_result = 16'h0042;
        stepClock();
        checkOutput("lu_valid", 32'(ex_valid), 32'h1);
        checkOutput("lu_rd", 32'(ex_rd), 32'h6);
        checkOutput("lu_a", 32'(ex_a), 32'h0007);
        checkOutput("lu_b", 32'(ex_b), 32'h0042);
        wb_reg_write = 0;

        // R0 guard on forwarding
        applyStimulus(1, 0, 2, 3, 1, 1, 16'h5555, 16'h0022, 16'h0, 0, ALU_OR, 1, 0, 0);
        mem_rd = 0; mem_reg_write = 1; mem_result = 16'hFFFF;
        stepClock();
        checkOutput("r0_a", 32'(ex_a), 32'h0000);
        checkOutput("r0_b", 32'(ex_b), 32'h0022);
        mem_reg_write = 0;

        // Load with rd=0 must not stall a consumer of R0
        applyStimulus(1, 2, 0, 0, 1, 0, 16'h0022, 16'h0, 16'h0008, 1, ALU_ADD, 1, 1, 0);
        stepClock();
        applyStimulus(1, 0, 0, 3, 1, 1, 16'h0, 16'h0, 16'h0, 0, ALU_ADD, 1, 0, 0);
        #1;
        checkOutput("r0_nostall", 32'(stall_id), 32'h0);

        // Flush outranks a load-use stall
        applyStimulus(1, 1, 0, 5, 1, 0, 16'h0100, 16'h0, 16'h0010, 1, ALU_ADD, 1, 1, 0);
        stepClock();
        applyStimulus(1, 2, 5, 6, 1, 1, 16'h0003, 16'h0009, 16'h0, 0, ALU_ADD, 1, 0, 0);
        flush = 1;
        #1;
        checkOutput("fl_stall", 32'(stall_id), 32'h1);
        stepClock();
        checkOutput("fl_valid", 32'(ex_valid), 32'h0);
        checkOutput("fl_mr", 32'(ex_mem_read), 32'h0);
        flush = 0;

        // Immediate op: ex_b takes imm, store data still forwarded rs2
        applyStimulus(1, 2, 3, 4, 1, 1, 16'h0001, 16'h1111, 16'hFFF8, 1, ALU_SHR, 1, 0, 0);
        mem_rd = 3; mem_reg_write = 1; mem_result = 16'h2222;
        stepClock();
        checkOutput("imm_b", 32'(ex_b), 32'hFFF8);
        checkOutput("imm_store", 32'(ex_store_data), 32'h2222);
        checkOutput("imm_alu", 32'(ex_alu_control), 32'(ALU_SHR));
        mem_reg_write = 0;

        // Asynchronous reset mid-stream with a load in EX and a stalled consumer
        applyStimulus(1, 1, 0, 5, 1, 0, 16'h0100, 16'h0, 16'h0010, 1, ALU_XOR, 1, 1, 0);
        stepClock();
        applyStimulus(1, 5, 2, 6, 1, 1, 16'h0003, 16'h0009, 16'h0, 0, ALU_ADD, 1, 0, 0);
        #1;
        checkOutput("mid_stall_pre", 32'(stall_id), 32'h1);
        checkOutput("mid_valid_pre", 32'(ex_valid), 32'h1);
        rst_n = 0;
        #1;
        checkOutput("mid_valid", 32'(ex_valid), 32'h0);
        checkOutput("mid_stall", 32'(stall_id), 32'h0);
        checkOutput("mid_a", 32'(ex_a), 32'h0);
        checkOutput("mid_b", 32'(ex_b), 32'h0);
        checkOutput("mid_store", 32'(ex_store_data), 32'h0);
        checkOutput("mid_alu", 32'(ex_alu_control), 32'h0);
        checkOutput("mid_rd", 32'(ex_rd), 32'h0);
        checkOutput("mid_rw", 32'(ex_reg_write), 32'h0);
        checkOutput("mid_mr", 32'(ex_mem_read), 32'h0);
        stepClock();
        checkOutput("mid_hold", 32'(ex_valid), 32'h0);
        rst_n = 1;

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 16-bit pipelined CPU, directly upstream of the ALU.
- Captures decoded operands and control each cycle.
- Resolves data hazards:
  - forwards MEM/WB results onto the ALU a/b operands;
  - detects load-use hazards, stalls ID and injects a bubble.
- Drives the ALU a, b and alu_control inputs combinationally from registered state.

Parameters:
- DATA_W, 16, datapath width
- REG_AW, 3, register index width (8 architectural registers; R0 reads as zero)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decoded instruction present in ID
- id_rs1, id_rs2, id_rd  in  REG_AW each  source/destination indices
- id_rs1_used, id_rs2_used  in  1 each  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  DATA_W each  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_use_imm  in  1  ALU b takes immediate instead of rs2
- id_alu_control  in  4  ALU opcode (0000 ADD … 0111 SHR)
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- flush  in  1  branch-taken squash of ID→EX transfer
- mem_rd  in  REG_AW;  mem_reg_write  in  1;  mem_result  in  DATA_W  (EX/MEM stage)
- wb_rd  in  REG_AW;  wb_reg_write  in  1;  wb_result  in  DATA_W  (MEM/WB stage)
- stall_id  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_a, ex_b  out  DATA_W each  ALU operands (forwarded)
- ex_alu_control  out  4  to ALU
- ex_store_data  out  DATA_W  forwarded rs2 value for stores
- ex_rd  out  REG_AW;  ex_reg_write, ex_mem_read, ex_mem_write  out  1 each

Behaviour:
- Reset (async, rst_n=0):
  - all registered fields clear: ex_valid=0, ex_rd=0, ex_alu_control=0000, all control bits 0, operand/imm registers 0.
  - As a result ex_a=ex_b=ex_store_data=0 and stall_id=0.
  - Release is synchronous to the next clk edge. Reset mid-stream discards the EX contents with no partial update.
- Register update every rising edge. Priority: flush > stall_id > normal.
  - flush=1: load bubble (valid, reg_write, mem_read, mem_write = 0; other fields don't-care, held at 0).
  - stall_id=1: load bubble; upstream holds ID, so the stalled instruction re-presents next cycle.
  - Otherwise: capture all id_* fields; control bits are ANDed with id_valid.
- Load-use detection (combinational, from registered EX and live ID):
  - Condition: stall_id = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - Exactly one bubble per load-use pair, because the bubble clears ex_mem_read the next cycle.
- Forwarding per source (rs1 and rs2 independently, from registered indices):
  - mem_reg_write & mem_rd≠0 & mem_rd==rsX → mem_result (highest priority; younger instruction wins);
  - else wb_reg_write & wb_rd≠0 & wb_rd==rsX → wb_result;
  - else registered register-file data.
  - rsX==0 always yields 0, regardless of the register data or forwarding.
- Operand outputs:
  - ex_a = fwd_rs1.
  - ex_b = registered use_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- Same-cycle register-file write/read in ID is handled by the register file (write-first), not here.
- Latency: one cycle ID→EX; forwarding and stall are zero-latency combinational paths.
- No arithmetic performed; all widths pass through unchanged.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and REG_AW;
  - ALU opcode localparams (ALU_ADD…ALU_SHR, matching the ALU encoding);
  - packed id_ex control struct {valid, rd, alu_control, use_imm, reg_write, mem_read, mem_write}.
- One sub-module, fwd_hazard_unit: purely combinational.
  - Computes the two forward selects and stall_id.
  - id_ex_stage instantiates it and owns the registers and operand muxes.

Test Plan:
- Reset with rst_n=0 mid-stream while ex_valid=1 → all ex_* outputs 0, stall_id=0 immediately (asynchronous).
- ADD R1←R2+R3 (data 0x0005, 0x0003), no hazards → next cycle ex_a=0x0005, ex_b=0x0003, ex_alu_control=0000, ex_rd=1, ex_reg_write=1.
- EX-to-EX forward: rs1=R4; mem_rd=4, mem_reg_write=1, mem_result=0x1234; wb_rd=4, wb_result=0xBEEF → ex_a=0x1234. Drop mem_reg_write → ex_a=0xBEEF.
- Load-use: LW R5 in EX (ex_mem_read=1, ex_rd=5), ID instruction uses rs2=R5 → stall_id=1 for exactly one cycle. Next cycle ex_valid=0 and ex_reg_write=0; following cycle the instruction enters EX.
- R0 guard: rs1=0 with mem_rd=0, mem_reg_write=1, mem_result=0xFFFF → ex_a=0x0000. A load with rd=0 in EX causes no stall.
- Flush vs stall: flush=1 in the same cycle as a load-use condition → bubble loaded, ex_valid=0. Immediate op with id_use_imm=1, imm=0xFFF8 → ex_b=0xFFF8 while ex_store_data still reflects forwarded rs2.
